// File: rtl/ifft_4.sv
// 4-point inverse FFT, two-stage radix-2 pipeline with clock enable.
// Outputs are (sum + 2) >>> 2, saturated to 3-bit signed, with a sticky overflow flag.
module ifft_4 (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              i_valid,
    input  logic signed [4:0] i_re0,
    input  logic signed [4:0] i_re1,
    input  logic signed [4:0] i_re2,
    input  logic signed [4:0] i_re3,
    input  logic signed [4:0] i_im0,
    input  logic signed [4:0] i_im1,
    input  logic signed [4:0] i_im2,
    input  logic signed [4:0] i_im3,
    output logic signed [2:0] o_re0,
    output logic signed [2:0] o_re1,
    output logic signed [2:0] o_re2,
    output logic signed [2:0] o_re3,
    output logic signed [2:0] o_im0,
    output logic signed [2:0] o_im1,
    output logic signed [2:0] o_im2,
    output logic signed [2:0] o_im3,
    output logic              o_valid,
    output logic              o_ovf
);

    function automatic logic signed [5:0] ext5(input logic signed [4:0] v);
        return {v[4], v};
    endfunction

    function automatic logic signed [6:0] ext6(input logic signed [5:0] v);
        return {v[5], v};
    endfunction

    // Round half up: bits [7:2] of (s + 2) are the floor of (s + 2) / 4.
    function automatic logic signed [5:0] rnd(input logic signed [6:0] s);
        logic signed [7:0] t;
        t = {s[6], s} + 8'sd2;
        return t[7:2];
    endfunction

    function automatic logic is_sat(input logic signed [6:0] s);
        logic signed [5:0] r;
        r = rnd(s);
        return (r > 6'sd3) || (r < -6'sd4);
    endfunction

    function automatic logic signed [2:0] rnd_sat(input logic signed [6:0] s);
        logic signed [5:0] r;
        logic signed [2:0] y;
        r = rnd(s);
        if (r > 6'sd3) begin
            y = 3'sd3;
        end else if (r < -6'sd4) begin
            y = -3'sd4;
        end else begin
            y = r[2:0];
        end
        return y;
    endfunction

    logic signed [4:0] x_re [4];
    logic signed [4:0] x_im [4];

    logic signed [5:0] a_re_d [4];
    logic signed [5:0] a_im_d [4];
    logic signed [5:0] a_re_q [4];
    logic signed [5:0] a_im_q [4];

    logic signed [6:0] s_re_d [4];
    logic signed [6:0] s_im_d [4];
    logic signed [6:0] s_re_q [4];
    logic signed [6:0] s_im_q [4];

    logic v1_q;
    logic v2_q;
    logic ovf_q;
    logic ovf_d;
    logic sat_s;

    assign x_re[0] = i_re0;
    assign x_re[1] = i_re1;
    assign x_re[2] = i_re2;
    assign x_re[3] = i_re3;
    assign x_im[0] = i_im0;
    assign x_im[1] = i_im1;
    assign x_im[2] = i_im2;
    assign x_im[3] = i_im3;

    // Stage 1 butterflies: even/odd pairs (X0,X2) and (X1,X3).
    always_comb begin
        a_re_d[0] = ext5(x_re[0]) + ext5(x_re[2]);
        a_im_d[0] = ext5(x_im[0]) + ext5(x_im[2]);
        a_re_d[1] = ext5(x_re[0]) - ext5(x_re[2]);
        a_im_d[1] = ext5(x_im[0]) - ext5(x_im[2]);
        a_re_d[2] = ext5(x_re[1]) + ext5(x_re[3]);
        a_im_d[2] = ext5(x_im[1]) + ext5(x_im[3]);
        a_re_d[3] = ext5(x_re[1]) - ext5(x_re[3]);
        a_im_d[3] = ext5(x_im[1]) - ext5(x_im[3]);
    end

    // Stage 2 butterflies; the odd pair uses the +j twiddle of the inverse transform.
    always_comb begin
        s_re_d[0] = ext6(a_re_q[0]) + ext6(a_re_q[2]);
        s_im_d[0] = ext6(a_im_q[0]) + ext6(a_im_q[2]);
        s_re_d[2] = ext6(a_re_q[0]) - ext6(a_re_q[2]);
        s_im_d[2] = ext6(a_im_q[0]) - ext6(a_im_q[2]);
        s_re_d[1] = ext6(a_re_q[1]) - ext6(a_im_q[3]);
        s_im_d[1] = ext6(a_im_q[1]) + ext6(a_re_q[3]);
        s_re_d[3] = ext6(a_re_q[1]) + ext6(a_im_q[3]);
        s_im_d[3] = ext6(a_im_q[1]) - ext6(a_re_q[3]);
    end

    // Overflow is judged on the set entering stage 2 so o_ovf rises together with o_valid.
    always_comb begin
        sat_s = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sat_s = sat_s | is_sat(s_re_d[k]) | is_sat(s_im_d[k]);
        end
        ovf_d = ovf_q | (v1_q & sat_s);
    end

    // Pipeline registers, valid bits and sticky overflow; all hold while en is low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                a_re_q[k] <= 6'sd0;
                a_im_q[k] <= 6'sd0;
                s_re_q[k] <= 7'sd0;
                s_im_q[k] <= 7'sd0;
            end
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < 4; k++) begin
                a_re_q[k] <= a_re_d[k];
                a_im_q[k] <= a_im_d[k];
                s_re_q[k] <= s_re_d[k];
                s_im_q[k] <= s_im_d[k];
            end
            v1_q  <= i_valid;
            v2_q  <= v1_q;
            ovf_q <= ovf_d;
        end else begin
            for (int k = 0; k < 4; k++) begin
                a_re_q[k] <= a_re_q[k];
                a_im_q[k] <= a_im_q[k];
                s_re_q[k] <= s_re_q[k];
                s_im_q[k] <= s_im_q[k];
            end
            v1_q  <= v1_q;
            v2_q  <= v2_q;
            ovf_q <= ovf_q;
        end
    end

    assign o_re0   = rnd_sat(s_re_q[0]);
    assign o_re1   = rnd_sat(s_re_q[1]);
    assign o_re2   = rnd_sat(s_re_q[2]);
    assign o_re3   = rnd_sat(s_re_q[3]);
    assign o_im0   = rnd_sat(s_im_q[0]);
    assign o_im1   = rnd_sat(s_im_q[1]);
    assign o_im2   = rnd_sat(s_im_q[2]);
    assign o_im3   = rnd_sat(s_im_q[3]);
    assign o_valid = v2_q;
    assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_ifft_4.sv
// Self-checking bench for ifft_4: fixed vector table, round trips of forward-FFT bins,
// random sets, stall and mid-stream reset, all checked through a scoreboard queue.
module tb_ifft_4;

    typedef struct packed {
        logic [3:0][2:0] re;
        logic [3:0][2:0] im;
        logic            valid;
        logic            sat;
    } exp_t;

    typedef struct packed {
        logic [3:0][4:0] xre;
        logic [3:0][4:0] xim;
        exp_t            ex;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic            i_valid;
    logic [3:0][4:0] d_re;
    logic [3:0][4:0] d_im;
    logic [2:0]      o_re0, o_re1, o_re2, o_re3;
    logic [2:0]      o_im0, o_im1, o_im2, o_im3;
    logic            o_valid;
    logic            o_ovf;

    exp_t sb[$];
    logic exp_ovf;
    int   n_chk = 0;
    int   n_fail = 0;
    int   valid_seen = 0;

    always #5 clk = ~clk;

    ifft_4 dut (
        .clk(clk), .rst(rst), .en(en), .i_valid(i_valid),
        .i_re0(d_re[0]), .i_re1(d_re[1]), .i_re2(d_re[2]), .i_re3(d_re[3]),
        .i_im0(d_im[0]), .i_im1(d_im[1]), .i_im2(d_im[2]), .i_im3(d_im[3]),
        .o_re0(o_re0), .o_re1(o_re1), .o_re2(o_re2), .o_re3(o_re3),
        .o_im0(o_im0), .o_im1(o_im1), .o_im2(o_im2), .o_im3(o_im3),
        .o_valid(o_valid), .o_ovf(o_ovf)
    );

    // Direct inverse DFT sum, then round half up and saturate.
    function automatic exp_t model(input logic [3:0][4:0] xr, input logic [3:0][4:0] xi);
        int   ar[4], ai[4], yr[4], yi[4];
        int   r;
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            ar[k] = int'($signed(xr[k]));
            ai[k] = int'($signed(xi[k]));
        end
        yr[0] = ar[0] + ar[1] + ar[2] + ar[3];
        yi[0] = ai[0] + ai[1] + ai[2] + ai[3];
        yr[1] = ar[0] - ai[1] - ar[2] + ai[3];
        yi[1] = ai[0] + ar[1] - ai[2] - ar[3];
        yr[2] = ar[0] - ar[1] + ar[2] - ar[3];
        yi[2] = ai[0] - ai[1] + ai[2] - ai[3];
        yr[3] = ar[0] + ai[1] - ar[2] - ai[3];
        yi[3] = ai[0] - ar[1] - ai[2] + ar[3];
        e = '0;
        for (int n = 0; n < 4; n++) begin
            r = (yr[n] + 2) >>> 2;
            if (r > 3) begin r = 3; e.sat = 1'b1; end
            else if (r < -4) begin r = -4; e.sat = 1'b1; end
            e.re[n] = 3'(r);
            r = (yi[n] + 2) >>> 2;
            if (r > 3) begin r = 3; e.sat = 1'b1; end
            else if (r < -4) begin r = -4; e.sat = 1'b1; end
            e.im[n] = 3'(r);
        end
        return e;
    endfunction

    // Random 3-bit samples, forward FFT to bins; expected output is the samples themselves.
    task automatic make_rt(output logic [3:0][4:0] xr, output logic [3:0][4:0] xi, output exp_t e);
        int sr[4], si[4];
        for (int n = 0; n < 4; n++) begin
            sr[n] = int'($urandom_range(0, 7)) - 4;
            si[n] = int'($urandom_range(0, 7)) - 4;
        end
        xr[0] = 5'(sr[0] + sr[1] + sr[2] + sr[3]);
        xi[0] = 5'(si[0] + si[1] + si[2] + si[3]);
        xr[1] = 5'(sr[0] + si[1] - sr[2] - si[3]);
        xi[1] = 5'(si[0] - sr[1] - si[2] + sr[3]);
        xr[2] = 5'(sr[0] - sr[1] + sr[2] - sr[3]);
        xi[2] = 5'(si[0] - si[1] + si[2] - si[3]);
        xr[3] = 5'(sr[0] - si[1] - sr[2] + si[3]);
        xi[3] = 5'(si[0] + sr[1] - si[2] - sr[3]);
        e = '0;
        for (int n = 0; n < 4; n++) begin
            e.re[n] = 3'(sr[n]);
            e.im[n] = 3'(si[n]);
        end
    endtask

    task automatic check(input string nm);
        logic [3:0][2:0] gr, gi;
        gr = {o_re3, o_re2, o_re1, o_re0};
        gi = {o_im3, o_im2, o_im1, o_im0};
        n_chk++;
        if (o_valid !== sb[0].valid || o_ovf !== exp_ovf || gr !== sb[0].re || gi !== sb[0].im) begin
            n_fail++;
            $display("FAIL %s @%0t: got v=%b ovf=%b re=%h im=%h, want v=%b ovf=%b re=%h im=%h",
                     nm, $time, o_valid, o_ovf, gr, gi, sb[0].valid, exp_ovf, sb[0].re, sb[0].im);
        end
    endtask

    task automatic step(input logic e, input logic v, input logic [3:0][4:0] xr,
                        input logic [3:0][4:0] xi, input exp_t ex, input string nm);
        exp_t rec;
        rec = ex;
        rec.valid = v;
        rst = 1'b1; en = e; i_valid = v; d_re = xr; d_im = xi;
        @(posedge clk);
        #1;
        if (e) begin
            sb.push_back(rec);
            void'(sb.pop_front());
            exp_ovf = exp_ovf | (sb[0].valid & sb[0].sat);
            if (o_valid) valid_seen++;
        end
        check(nm);
    endtask

    task automatic do_reset(input logic e, input string nm);
        rst = 1'b0; en = e; i_valid = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        sb.push_back('0);
        sb.push_back('0);
        exp_ovf = 1'b0;
        check(nm);
    endtask

    task automatic step_rand(input logic e, input logic v, input string nm);
        logic [3:0][4:0] xr, xi;
        exp_t ex;
        make_rt(xr, xi, ex);
        step(e, v, xr, xi, ex, nm);
    endtask

    vec_t tbl[6];
    logic [3:0][4:0] zr, rr, ri;
    exp_t ez;
    int   base;

    initial begin
        zr = '0;
        ez = '0;
        rst = 1'b0; en = 1'b0; i_valid = 1'b0; d_re = '0; d_im = '0;
        exp_ovf = 1'b0;

        foreach (tbl[i]) tbl[i] = '0;
        // Round trip: X = (8, 3+1j, -2, 3-1j) -> (3,2,0,3)
        tbl[0].xre[0] = 5'd8;  tbl[0].xre[1] = 5'd3; tbl[0].xim[1] = 5'd1;
        tbl[0].xre[2] = 5'h1E; tbl[0].xre[3] = 5'd3; tbl[0].xim[3] = 5'h1F;
        tbl[0].ex.re[0] = 3'd3; tbl[0].ex.re[1] = 3'd2; tbl[0].ex.re[2] = 3'd0; tbl[0].ex.re[3] = 3'd3;
        // DC bin X0 = 4 -> all 1
        tbl[1].xre[0] = 5'd4;
        for (int n = 0; n < 4; n++) tbl[1].ex.re[n] = 3'd1;
        // Rounding: X0 = 2 -> 1, X0 = -2 -> 0, X0 = 1 -> 0
        tbl[2].xre[0] = 5'd2;
        for (int n = 0; n < 4; n++) tbl[2].ex.re[n] = 3'd1;
        tbl[3].xre[0] = 5'h1E;
        tbl[4].xre[0] = 5'd1;
        // Saturation: all real bins 4 -> re0 clips to +3
        for (int n = 0; n < 4; n++) tbl[5].xre[n] = 5'd4;
        tbl[5].ex.re[0] = 3'd3;
        tbl[5].ex.sat = 1'b1;

        do_reset(1'b0, "reset_state");
        do_reset(1'b1, "reset_state_en");

        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, tbl[i].xre, tbl[i].xim, tbl[i].ex, "table");
        step(1'b1, 1'b1, zr, zr, ez, "table_flush");
        step(1'b1, 1'b1, zr, zr, ez, "ovf_sticky");
        step(1'b1, 1'b0, zr, zr, ez, "ovf_sticky_inv");
        step(1'b0, 1'b1, zr, zr, ez, "ovf_hold");
        do_reset(1'b0, "ovf_cleared");

        // Invalid saturating set must not raise overflow.
        step(1'b1, 1'b0, tbl[5].xre, tbl[5].xim, tbl[5].ex, "inv_sat");
        step(1'b1, 1'b0, zr, zr, ez, "inv_sat_a");
        step(1'b1, 1'b0, zr, zr, ez, "inv_sat_b");

        // Stall: three valid sets with a five-cycle en=0 gap.
        base = valid_seen;
        step_rand(1'b1, 1'b1, "stall_a");
        step_rand(1'b1, 1'b1, "stall_b");
        for (int i = 0; i < 5; i++) step_rand(1'b0, 1'b1, "stall_hold");
        step_rand(1'b1, 1'b1, "stall_c");
        step(1'b1, 1'b0, zr, zr, ez, "stall_flush1");
        step(1'b1, 1'b0, zr, zr, ez, "stall_flush2");
        n_chk++;
        if (valid_seen - base != 3) begin
            n_fail++;
            $display("FAIL stall_count: got %0d results, want 3", valid_seen - base);
        end

        // Mid-stream reset discards in-flight sets.
        for (int i = 0; i < 4; i++) step_rand(1'b1, 1'b1, "pre_reset");
        step(1'b1, 1'b1, tbl[5].xre, tbl[5].xim, tbl[5].ex, "pre_reset_sat");
        do_reset(1'b1, "mid_reset");
        step(1'b1, 1'b0, zr, zr, ez, "post_reset1");
        step(1'b1, 1'b1, tbl[0].xre, tbl[0].xim, tbl[0].ex, "post_reset2");
        step(1'b1, 1'b0, zr, zr, ez, "post_reset3");
        step(1'b1, 1'b0, zr, zr, ez, "post_reset4");

        // Random mix: round-trip sets and arbitrary bins, random enable and valid.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                step_rand($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, "rand_rt");
            end else begin
                rr = 20'($urandom);
                ri = 20'($urandom);
                step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, rr, ri, model(rr, ri), "rand_model");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
